// File: rtl/digct_event_monitor.sv
// digct_event_monitor: per-channel rising-edge counters, IN1->IN2->IN3 timed
// sequence detector and a registered counter readout port.
// Optional build macro: DIGCT_MON_OVF_EN adds the sticky OVF[2:0] flags.
module digct_event_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN1,
  input  logic             IN2,
  input  logic             IN3,
  input  logic             CLR,
  input  logic [1:0]       SEL,
  output logic [CNT_W-1:0] DOUT,
  output logic             SEQ_DET
`ifdef DIGCT_MON_OVF_EN
  ,
  output logic [2:0]       OVF
`endif
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // The timer reads 0 on the first edge after entry, so it reads TIMEOUT-2
  // on edge TIMEOUT-1: the last edge a step is accepted and the edge the
  // FSM gives up if nothing qualifying arrived.
  localparam logic [TIMER_W-1:0] TMR_LAST = TIMER_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TIMER_W-1:0] timer;
  logic               tmr_rst_c;
  logic               det_c;
  logic [2:0]         in_c;
  logic [2:0]         prev;
  logic [2:0]         rise_c;
  logic [CNT_W-1:0]   cnt [3];
  logic [CNT_W-1:0]   seq_cnt;

  assign in_c   = {IN3, IN2, IN1};
  assign rise_c = in_c & ~prev;

  // Previous-level capture; loading during reset keeps a held-high input
  // from looking like an edge once reset releases.
  always_ff @(posedge CLK) begin
    prev <= in_c;
  end

  // Per-channel saturating event counters; CLR wins over a coincident rise.
  always_ff @(posedge CLK) begin
    if (!RST || CLR) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rise_c[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Sequence FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Sequence FSM next state, timer restart and detection strobe.
  always_comb begin
    state_nxt = state;
    tmr_rst_c = 1'b0;
    det_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise_c[0]) begin
          state_nxt = GOT1;
          tmr_rst_c = 1'b1;
        end
      end
      GOT1: begin
        if (rise_c[1]) begin
          state_nxt = GOT2;
          tmr_rst_c = 1'b1;
        end else if (rise_c[0]) begin
          state_nxt = GOT1;
          tmr_rst_c = 1'b1;
        end else if (timer == TMR_LAST) begin
          state_nxt = IDLE;
          tmr_rst_c = 1'b1;
        end
      end
      GOT2: begin
        if (rise_c[2]) begin
          state_nxt = IDLE;
          tmr_rst_c = 1'b1;
          det_c     = 1'b1;
        end else if (rise_c[0]) begin
          state_nxt = GOT1;
          tmr_rst_c = 1'b1;
        end else if (timer == TMR_LAST) begin
          state_nxt = IDLE;
          tmr_rst_c = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_rst_c = 1'b1;
      end
    endcase
    if (CLR) begin
      state_nxt = IDLE;
      tmr_rst_c = 1'b1;
      det_c     = 1'b0;
    end
  end

  // Step timer: zero on every (re)entry and while idle, counts in GOT1/GOT2.
  always_ff @(posedge CLK) begin
    if (!RST || tmr_rst_c || (state == IDLE)) timer <= '0;
    else                                      timer <= timer + TIMER_W'(1);
  end

  // Detection pulse and saturating sequence counter.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      SEQ_DET <= 1'b0;
      seq_cnt <= '0;
    end else begin
      SEQ_DET <= det_c;
      if (CLR)                                  seq_cnt <= '0;
      else if (det_c && (seq_cnt != CNT_MAX))   seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end

  // Registered readout; shows pre-clear values in a CLR cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      DOUT <= '0;
    end else begin
      unique case (SEL)
        2'd0: DOUT <= cnt[0];
        2'd1: DOUT <= cnt[1];
        2'd2: DOUT <= cnt[2];
        2'd3: DOUT <= seq_cnt;
      endcase
    end
  end

`ifdef DIGCT_MON_OVF_EN
  // Sticky overflow flags: a rise arriving while the counter is saturated.
  always_ff @(posedge CLK) begin
    if (!RST || CLR) begin
      OVF <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rise_c[i] && (cnt[i] == CNT_MAX)) OVF[i] <= 1'b1;
      end
    end
  end
`endif

endmodule
